// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes and debounces the clock-generator lock, then releases
// the peripheral reset followed by the core reset. Optional lock-loss counter: RSTSEQ_LOSS_CNT_EN.
module rst_sequencer #(
   parameter int LockStableCycles = 1024,
   parameter int StageGapCycles   = 16,
   parameter int SyncStages       = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       locked_i,
   input  logic       srst_req_i,
   output logic       rst_periph_no,
   output logic       rst_core_no,
   output logic       ready_o,
   output logic       lock_lost_o,
   output logic [7:0] loss_cnt_o
);

   localparam int MaxCycles = (LockStableCycles > StageGapCycles) ? LockStableCycles : StageGapCycles;
   localparam int CntWidth  = $clog2(MaxCycles + 1);
   localparam logic [CntWidth-1:0] DebounceLast = CntWidth'(LockStableCycles - 1);
   localparam logic [CntWidth-1:0] GapLast      = CntWidth'(StageGapCycles - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK,
      DEBOUNCE,
      PERIPH,
      RUN,
      HOLD
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [CntWidth-1:0]   cnt;
   logic [CntWidth-1:0]   cnt_next;
   logic [SyncStages-1:0] sync_q;
   logic                  locked_s;
   logic                  lock_drop;
   logic                  lose_lock;
   logic                  restart;

   assign locked_s  = sync_q[SyncStages-1];
   assign lock_drop = !locked_s && (state == DEBOUNCE || state == PERIPH || state == RUN);
   // Only a loss after the peripheral reset was released counts as a real lock loss.
   assign lose_lock = lock_drop && (state == PERIPH || state == RUN);

   always_comb begin
      state_next = state;
      restart    = 1'b0;
      if (lock_drop) begin
         state_next = WAIT_LOCK;
      end else if (srst_req_i && state != WAIT_LOCK) begin
         state_next = HOLD;
         restart    = 1'b1;
      end else begin
         case (state)
            WAIT_LOCK: if (locked_s) state_next = DEBOUNCE;
            DEBOUNCE:  if (cnt == DebounceLast) state_next = PERIPH;
            PERIPH:    if (cnt == GapLast) state_next = RUN;
            HOLD:      if (cnt == GapLast) state_next = WAIT_LOCK;
            default:   state_next = state;
         endcase
      end
   end

   always_comb begin
      cnt_next = '0;
      if (state_next == state && !restart &&
          (state == DEBOUNCE || state == PERIPH || state == HOLD)) begin
         cnt_next = cnt + CntWidth'(1);
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q        <= '0;
         state         <= WAIT_LOCK;
         cnt           <= '0;
         rst_periph_no <= 1'b0;
         rst_core_no   <= 1'b0;
         ready_o       <= 1'b0;
         lock_lost_o   <= 1'b0;
      end else begin
         sync_q        <= {sync_q[SyncStages-2:0], locked_i};
         state         <= state_next;
         cnt           <= cnt_next;
         rst_periph_no <= (state_next == PERIPH) || (state_next == RUN);
         rst_core_no   <= (state_next == RUN);
         ready_o       <= (state_next == RUN);
         lock_lost_o   <= lose_lock;
      end
   end

`ifdef RSTSEQ_LOSS_CNT_EN
   logic [7:0] loss_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         loss_cnt_q <= 8'h00;
      end else if (lose_lock && loss_cnt_q != 8'hFF) begin
         loss_cnt_q <= loss_cnt_q + 8'd1;
      end
   end

   assign loss_cnt_o = loss_cnt_q;
`else
   assign loss_cnt_o = 8'h00;
`endif

endmodule
